// File: rtl/fdt16_pkg.sv
// Shared definitions for the FDT16 data-memory path: request op codes, the
// memory sequencer FSM encoding and default datapath widths.
package fdt16_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 9;
    localparam int SP_W_DEF   = 16;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_PUSH  = 2'b10;
    localparam logic [1:0] OP_POP   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } mau_state_t;

    // Ops whose response carries memory read data and so need the WAIT cycle.
    function automatic logic op_reads(input logic [1:0] op);
        return (op == OP_LOAD) || (op == OP_POP);
    endfunction

endpackage

// File: rtl/stack_ptr_ctrl.sv
// Stack pointer and depth bookkeeping for a downward-growing stack.
// Full/empty come from the depth count alone, so SP never has to be compared.
module stack_ptr_ctrl #(
    parameter int              SP_W        = 16,
    parameter logic [SP_W-1:0] SP_TOP      = 16'hFFFF,
    parameter int              STACK_DEPTH = 256,
    parameter int              DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_en,
    input  logic               pop_en,
    output logic [SP_W-1:0]    sp,
    output logic [SP_W-1:0]    sp_plus1,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    logic [SP_W-1:0]    sp_reg;
    logic [SP_W-1:0]    sp_next;
    logic [DEPTH_W-1:0] depth_reg;
    logic [DEPTH_W-1:0] depth_next;

    assign full     = (depth_reg == DEPTH_W'(STACK_DEPTH));
    assign empty    = (depth_reg == '0);
    assign sp       = sp_reg;
    assign sp_plus1 = sp_reg + SP_W'(1);
    assign depth    = depth_reg;

    // The bound checks here are a second line of defence; the sequencer
    // already refuses to strobe a push when full or a pop when empty.
    always_comb begin
        sp_next    = sp_reg;
        depth_next = depth_reg;
        if (push_en && !full) begin
            sp_next    = sp_reg - SP_W'(1);
            depth_next = depth_reg + DEPTH_W'(1);
        end else if (pop_en && !empty) begin
            sp_next    = sp_reg + SP_W'(1);
            depth_next = depth_reg - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_reg    <= SP_TOP;
            depth_reg <= '0;
        end else begin
            sp_reg    <= sp_next;
            depth_reg <= depth_next;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Request sequencer in front of the data memory: one load/store/push/pop at a
// time, owns the stack pointer, and returns a held response with error flag.
module mem_access_unit
    import fdt16_pkg::*;
#(
    parameter int              DATA_W      = DATA_W_DEF,
    parameter int              ADDR_W      = ADDR_W_DEF,
    parameter int              SP_W        = SP_W_DEF,
    parameter logic [SP_W-1:0] SP_TOP      = 16'hFFFF,
    parameter int              STACK_DEPTH = 256,
    parameter int              DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [DATA_W-1:0]  req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               rsp_err,
    output logic               mem_store,
    output logic               mem_load,
    output logic               mem_push,
    output logic               mem_pop,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [SP_W-1:0]    mem_sp,
    output logic [DATA_W-1:0]  mem_data_in,
    input  logic [DATA_W-1:0]  mem_data_out,
    output logic [SP_W-1:0]    sp_value,
    output logic [DEPTH_W-1:0] stack_depth
);

    mau_state_t        state_reg, state_next;
    logic [1:0]        op_reg, op_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              err_reg, err_next;

    logic [3:0]        strobe_vec;
    logic [SP_W-1:0]   sp;
    logic [SP_W-1:0]   sp_plus1;
    logic [DEPTH_W-1:0] depth;
    logic              full;
    logic              empty;

    stack_ptr_ctrl #(
        .SP_W        (SP_W),
        .SP_TOP      (SP_TOP),
        .STACK_DEPTH (STACK_DEPTH),
        .DEPTH_W     (DEPTH_W)
    ) u_stack_ptr_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_en  (strobe_vec[OP_PUSH]),
        .pop_en   (strobe_vec[OP_POP]),
        .sp       (sp),
        .sp_plus1 (sp_plus1),
        .depth    (depth),
        .full     (full),
        .empty    (empty)
    );

    // One strobe per op code, live only in ISSUE, so reset kills them at once.
    for (genvar gi = 0; gi < 4; gi++) begin : g_strobe
        assign strobe_vec[gi] = (state_reg == S_ISSUE) && (op_reg == 2'(gi));
    end

    assign mem_load    = strobe_vec[OP_LOAD];
    assign mem_store   = strobe_vec[OP_STORE];
    assign mem_push    = strobe_vec[OP_PUSH];
    assign mem_pop     = strobe_vec[OP_POP];
    // A pop reads the slot just above SP; everything else points at SP.
    assign mem_sp      = mem_pop ? sp_plus1 : sp;
    assign mem_address = addr_reg;
    assign mem_data_in = wdata_reg;

    assign req_ready   = (state_reg == S_IDLE);
    assign rsp_valid   = (state_reg == S_RESP);
    assign rsp_rdata   = rdata_reg;
    assign rsp_err     = err_reg;
    assign sp_value    = sp;
    assign stack_depth = depth;

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        unique case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    op_next    = req_op;
                    addr_next  = req_addr;
                    wdata_next = req_wdata;
                    // Stack bound violations answer straight away without touching memory.
                    if ((req_op == OP_PUSH && full) || (req_op == OP_POP && empty)) begin
                        state_next = S_RESP;
                        err_next   = 1'b1;
                        rdata_next = '0;
                    end else begin
                        state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (op_reads(op_reg)) begin
                    state_next = S_WAIT;
                end else begin
                    state_next = S_RESP;
                    err_next   = 1'b0;
                    rdata_next = '0;
                end
            end
            S_WAIT: begin
                state_next = S_RESP;
                err_next   = 1'b0;
                rdata_next = mem_data_out;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            op_reg    <= OP_LOAD;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by
// random traffic, compared against a queue/array model of memory and stack.
module tb_mem_access_unit;
    import fdt16_pkg::*;

    localparam int              DATA_W      = 16;
    localparam int              ADDR_W      = 9;
    localparam int              SP_W        = 16;
    localparam logic [SP_W-1:0] SP_TOP      = 16'hFFFF;
    localparam int              STACK_DEPTH = 4;
    localparam int              DEPTH_W     = $clog2(STACK_DEPTH + 1);

    logic               clk;
    logic               rst_n;
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_op;
    logic [ADDR_W-1:0]  req_addr;
    logic [DATA_W-1:0]  req_wdata;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [DATA_W-1:0]  rsp_rdata;
    logic               rsp_err;
    logic               mem_store;
    logic               mem_load;
    logic               mem_push;
    logic               mem_pop;
    logic [ADDR_W-1:0]  mem_address;
    logic [SP_W-1:0]    mem_sp;
    logic [DATA_W-1:0]  mem_data_in;
    logic [DATA_W-1:0]  mem_data_out;
    logic [SP_W-1:0]    sp_value;
    logic [DEPTH_W-1:0] stack_depth;
    logic [3:0]         strobes;

    int n_cmp = 0;
    int n_mis = 0;

    mem_access_unit #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .SP_W        (SP_W),
        .SP_TOP      (SP_TOP),
        .STACK_DEPTH (STACK_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_store    (mem_store),
        .mem_load     (mem_load),
        .mem_push     (mem_push),
        .mem_pop      (mem_pop),
        .mem_address  (mem_address),
        .mem_sp       (mem_sp),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .sp_value     (sp_value),
        .stack_depth  (stack_depth)
    );

    assign strobes = {mem_pop, mem_push, mem_store, mem_load};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memory: synchronous read, data valid the cycle after a strobe,
    // garbage otherwise so a mistimed capture is visible.
    logic [DATA_W-1:0] tb_mem [0:65535];
    initial for (int i = 0; i < 65536; i++) tb_mem[i] = '0;

    always @(posedge clk) begin
        if (mem_store) tb_mem[{7'd0, mem_address}] <= mem_data_in;
        if (mem_push)  tb_mem[mem_sp] <= mem_data_in;
        if (mem_load)      mem_data_out <= tb_mem[{7'd0, mem_address}];
        else if (mem_pop)  mem_data_out <= tb_mem[mem_sp];
        else               mem_data_out <= 16'($urandom);
    end

    // Reference model: flat data array plus a LIFO of pushed words.
    logic [DATA_W-1:0] ref_data [0:511];
    logic [DATA_W-1:0] ref_stack [$];
    initial for (int i = 0; i < 512; i++) ref_data[i] = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) chk("strobe_onehot0", 32'($onehot0(strobes)), 32'd1);
    end

    a_strobe_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(strobes))
        else $error("FAIL strobe_assert: strobes=%b", strobes);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One full request/response exchange; called and returns on a falling edge.
    task automatic xact(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, input int hold, input bit poke);
        int                depth;
        bit                exp_err;
        int                exp_lat;
        int                exp_code;
        logic [DATA_W-1:0] exp_rdata;
        logic [SP_W-1:0]   exp_msp;
        int                cyc;
        int                n_strb;
        int                code;
        logic [SP_W-1:0]   seen_msp;
        logic [ADDR_W-1:0] seen_addr;
        logic [DATA_W-1:0] seen_din;

        depth     = ref_stack.size();
        exp_err   = (op == OP_PUSH && depth == STACK_DEPTH) || (op == OP_POP && depth == 0);
        exp_lat   = exp_err ? 1 : ((op == OP_LOAD || op == OP_POP) ? 3 : 2);
        exp_code  = exp_err ? 0 : int'(op) + 1;
        exp_rdata = '0;
        exp_msp   = (op == OP_POP) ? 16'(SP_TOP - depth + 1) : 16'(SP_TOP - depth);
        if (!exp_err) begin
            case (op)
                OP_LOAD:  exp_rdata = ref_data[addr];
                OP_STORE: ref_data[addr] = wd;
                OP_PUSH:  ref_stack.push_back(wd);
                default:  exp_rdata = ref_stack.pop_back();
            endcase
        end

        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_addr  = 9'($urandom);
        req_wdata = 16'($urandom);

        cyc = 1; n_strb = 0; code = 0;
        seen_msp = '0; seen_addr = '0; seen_din = '0;
        while (1) begin
            if (strobes != 4'b0) begin
                n_strb++;
                code      = mem_load ? 1 : mem_store ? 2 : mem_push ? 3 : 4;
                seen_msp  = mem_sp;
                seen_addr = mem_address;
                seen_din  = mem_data_in;
            end
            if (rsp_valid || cyc >= 8) break;
            @(negedge clk);
            cyc++;
        end

        chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
        chk("rsp_latency", 32'(cyc), 32'(exp_lat));
        chk("strobe_count", 32'(n_strb), exp_err ? 32'd0 : 32'd1);
        chk("strobe_kind", 32'(code), 32'(exp_code));
        if (!exp_err && (op == OP_LOAD || op == OP_STORE)) chk("mem_address", 32'(seen_addr), 32'(addr));
        if (!exp_err && (op == OP_STORE || op == OP_PUSH)) chk("mem_data_in", 32'(seen_din), 32'(wd));
        if (!exp_err && (op == OP_PUSH || op == OP_POP))   chk("mem_sp", 32'(seen_msp), 32'(exp_msp));
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));

        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                req_valid = 1'b1;
                req_op    = 2'($urandom);
                req_addr  = 9'($urandom);
                req_wdata = 16'($urandom);
            end
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
            chk("hold_rsp_err", 32'(rsp_err), 32'(exp_err));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_no_strobe", 32'(strobes), 32'd0);
        end

        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("sp_value", 32'(sp_value), 32'(16'(SP_TOP - ref_stack.size())));
        chk("stack_depth", 32'(stack_depth), 32'(ref_stack.size()));
        $display("xact op=%0d addr=%h wdata=%h -> err=%0d rdata=%h lat=%0d depth=%0d sp=%h",
                 op, addr, wd, rsp_err, exp_rdata, cyc, stack_depth, sp_value);
    endtask

    initial begin
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_op    = OP_LOAD;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_strobes", 32'(strobes), 32'd0);
        chk("reset_sp", 32'(sp_value), 32'(SP_TOP));
        chk("reset_depth", 32'(stack_depth), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Empty-stack pop, then store/load round trip.
        xact(OP_POP, 9'h000, 16'h0000, 0, 1'b0);
        xact(OP_STORE, 9'h005, 16'hBEEF, 0, 1'b0);
        xact(OP_LOAD, 9'h005, 16'h0000, 0, 1'b0);

        // LIFO order and SP addresses.
        xact(OP_PUSH, 9'h000, 16'h1111, 0, 1'b0);
        xact(OP_PUSH, 9'h000, 16'h2222, 0, 1'b0);
        xact(OP_POP, 9'h000, 16'h0000, 0, 1'b0);
        xact(OP_POP, 9'h000, 16'h0000, 0, 1'b0);

        // Fill past capacity, then drain past empty.
        for (int i = 0; i < STACK_DEPTH + 1; i++) xact(OP_PUSH, 9'h000, 16'hA000 + 16'(i), 0, 1'b0);
        for (int i = 0; i < STACK_DEPTH + 1; i++) xact(OP_POP, 9'h000, 16'h0000, 0, 1'b0);

        // Back-pressured response with ignored requests during the hold.
        xact(OP_LOAD, 9'h005, 16'h0000, 5, 1'b1);

        // Reset during a push's ISSUE cycle.
        xact(OP_PUSH, 9'h000, 16'h3333, 0, 1'b0);
        req_valid = 1'b1;
        req_op    = OP_PUSH;
        req_wdata = 16'h4444;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_mid_push_strobe", 32'(mem_push), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_strobes", 32'(strobes), 32'd0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        ref_stack.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_after_sp", 32'(sp_value), 32'(SP_TOP));
        chk("rst_after_depth", 32'(stack_depth), 32'd0);
        chk("rst_after_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_after_req_ready", 32'(req_ready), 32'd1);
        $display("reset mid-push: sp=%h depth=%0d", sp_value, stack_depth);

        // Random traffic over a small address window so loads hit earlier stores.
        for (int i = 0; i < 80; i++) begin
            xact(2'($urandom_range(0, 3)), 9'($urandom_range(0, 15)), 16'($urandom),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
